pdm_capture_multi: RTL and testbench

- Parametrised PDM capture controller. Deserialises 1..2 PDM microphone channels sharing one data line (ch0 on PCLK rising edge, ch1 on falling edge) into WORD_W-bit words.
- Writes words to sample memory through a valid/ready write port at sequential addresses.
- Supports single-shot (stop at DEPTH words) and continuous (ring-buffer wrap) modes, software start/stop, and overflow detection.
- Runs entirely in ahb_clk; the PDM clock is oversampled, not used as a clock.

---
 rtl/pdm_pkg.sv | 7 +
 rtl/pdm_capture_multi_deser.sv | 54 +++++
 rtl/pdm_capture_multi.sv | 121 ++++++++++++
 tb/tb_pdm_capture_multi.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared FSM encoding and default sizing for the PDM capture block
package pdm_pkg;
    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, DRAIN, DONE} state_t;
    localparam int WORD_W_DEF = 32;
    localparam int DEPTH_DEF  = 49152;
    localparam int ADDR_W_DEF = 16;
endpackage

// File: rtl/pdm_capture_multi_deser.sv
// pdm_deser: resynchronises the PDM clock/data pair and shifts one channel's bits on its edge
module pdm_deser
    import pdm_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int SYNC_STG = 2
) (
    input  logic              ahb_clk,
    input  logic              rst,
    input  logic              i_pdm_clk,
    input  logic              i_pdm_data,
    input  logic              i_fall,
    input  logic              i_en,
    input  logic              i_clr,
    output logic              o_shift,
    output logic              o_done,
    output logic [WORD_W-1:0] o_word
);
    localparam int CW = $clog2(WORD_W);
    logic [SYNC_STG-1:0] r_clk_sync, r_dat_sync;
    logic                r_clk_prev;
    logic [WORD_W-2:0]   r_shift;
    logic [CW-1:0]       r_cnt;
    logic                w_cur, w_dat, w_edge;

    // clock and data share identical chains so the sampled bit lines up with its edge
    assign w_cur   = r_clk_sync[SYNC_STG-1];
    assign w_dat   = r_dat_sync[SYNC_STG-1];
    assign w_edge  = i_fall ? (r_clk_prev && !w_cur) : (!r_clk_prev && w_cur);
    assign o_shift = i_en && w_edge;
    assign o_word  = {r_shift, w_dat};
    assign o_done  = o_shift && r_cnt == '0;

    always_ff @(posedge ahb_clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync <= '0;
            r_dat_sync <= '0;
            r_clk_prev <= 1'b0;
            r_shift    <= '0;
            r_cnt      <= CW'(WORD_W - 1);
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STG-2:0], i_pdm_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STG-2:0], i_pdm_data};
            r_clk_prev <= w_cur;
            if (i_clr) begin
                r_shift <= '0;
                r_cnt   <= CW'(WORD_W - 1);
            end else if (o_shift) begin
                r_shift <= o_word[WORD_W-2:0];
                r_cnt   <= r_cnt == '0 ? CW'(WORD_W - 1) : r_cnt - CW'(1);
            end
        end
    end
endmodule

// File: rtl/pdm_capture_multi.sv
// pdm_capture_multi: captures 1..2 PDM channels from a shared data line into sequential memory words
module pdm_capture_multi
    import pdm_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int CH       = 2,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int SYNC_STG = 2
) (
    input  logic              ahb_clk,
    input  logic              rst,
    input  logic              pdm_clk_in,
    input  logic              pdm_data,
    input  logic              start,
    input  logic              stop,
    input  logic              cont,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              wr_ch,
    output logic              bsy,
    output logic              done,
    output logic              wrap,
    output logic              ovf
);
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_cont, r_ovf, r_wrap, r_lock, r_lsel;
    logic [CH-1:0]     w_vld, w_shift, w_done, w_serve, w_ovf;
    logic [WORD_W-1:0] w_hold [CH];
    logic [WORD_W-1:0] w_word [CH];
    logic              w_clr, w_flush, w_sel, w_acc, w_end, w_last;

    assign w_clr   = r_state == IDLE && start;
    assign w_flush = r_state inside {IDLE, DONE};
    // a presented but unaccepted word keeps its channel even if ch0 completes meanwhile
    assign w_sel    = r_lock ? r_lsel : (CH == 2 && !w_vld[0]);
    assign wr_valid = |w_vld && r_state inside {CAPTURE, DRAIN};
    assign w_acc    = wr_valid && wr_ready;
    assign w_end    = w_acc && r_addr == ADDR_W'(DEPTH - 1);
    assign w_last   = w_end && !r_cont;
    assign wr_addr  = r_addr;
    assign wr_data  = w_sel ? w_hold[CH-1] : w_hold[0];
    assign wr_ch    = w_sel;
    assign bsy      = r_state inside {ARM, CAPTURE, DRAIN};
    assign done     = r_state == DONE;
    assign wrap     = r_wrap;
    assign ovf      = r_ovf;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic              r_v;
        logic [WORD_W-1:0] r_h;
        pdm_deser #(.WORD_W(WORD_W), .SYNC_STG(SYNC_STG)) u_deser (
            .ahb_clk    (ahb_clk),
            .rst        (rst),
            .i_pdm_clk  (pdm_clk_in),
            .i_pdm_data (pdm_data),
            .i_fall     (1'(g)),
            .i_en       (r_state == CAPTURE || (g == 0 && r_state == ARM)),
            .i_clr      (w_clr),
            .o_shift    (w_shift[g]),
            .o_done     (w_done[g]),
            .o_word     (w_word[g])
        );
        assign w_serve[g] = w_acc && w_sel == 1'(g);
        assign w_ovf[g]   = w_done[g] && r_v && !w_serve[g];
        assign w_vld[g]   = r_v;
        assign w_hold[g]  = r_h;
        always_ff @(posedge ahb_clk or negedge rst) begin
            if (!rst) begin
                r_v <= 1'b0;
                r_h <= '0;
            end else if (w_flush) begin
                r_v <= 1'b0;
                r_h <= '0;
            end else if (w_done[g] && (!r_v || w_serve[g])) begin
                r_v <= 1'b1;
                r_h <= w_word[g];
            end else if (w_serve[g]) begin
                r_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge ahb_clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cont  <= 1'b0;
            r_ovf   <= 1'b0;
            r_wrap  <= 1'b0;
            r_lock  <= 1'b0;
            r_lsel  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wrap  <= w_end && r_cont;
            r_lock  <= wr_valid && !wr_ready;
            r_lsel  <= w_sel;
            r_ovf   <= !w_clr && (r_ovf || |w_ovf);
            if (w_clr) begin
                r_cont <= cont;
                r_addr <= '0;
            end else if (w_acc && !w_last) begin
                r_addr <= w_end ? '0 : r_addr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? ARM : IDLE;
            ARM:     w_next = stop ? DONE : (|w_shift ? CAPTURE : ARM);
            CAPTURE: w_next = w_last ? DONE : (stop ? DRAIN : CAPTURE);
            DRAIN:   w_next = (w_last || !(|w_vld)) ? DONE : DRAIN;
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pdm_capture_multi.sv
// tb_pdm_capture_multi: directed scoreboard bench driving a mono and a stereo capture instance
module tb_pdm_capture_multi;
    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
        logic       ch;
    } wr_t;

    logic       ahb_clk = 1'b0, rst = 1'b0, pclk = 1'b0, pdat = 1'b0;
    logic       start_m = 1'b0, stop_m = 1'b0, cont_m = 1'b0, rdy_m = 1'b1;
    logic       start_s = 1'b0, stop_s = 1'b0, cont_s = 1'b0, rdy_s = 1'b1;
    logic       val_m, val_s, ch_m, ch_s, bsy_m, bsy_s, done_m, done_s;
    logic       wrap_m, wrap_s, ovf_m, ovf_s;
    logic [1:0] addr_m, addr_s, last_addr_m;
    logic [7:0] data_m, data_s;
    logic       done_bsy_m, done_bsy_s;
    int         n_assert = 0, n_fail = 0, cyc = 0, wrap_cnt = 0;
    int         done_cnt_m = 0, done_cnt_s = 0, done_cyc_m = 0, done_cyc_s = 0;
    int         acc_cyc_m = 0, acc_cyc_s = 0, base;
    wr_t        qm[$], qs[$];
    wr_t        em, es;
    logic [7:0] pat [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

    pdm_capture_multi #(.WORD_W(8), .CH(1), .DEPTH(4), .ADDR_W(2), .SYNC_STG(2)) u_mono (
        .ahb_clk(ahb_clk), .rst(rst), .pdm_clk_in(pclk), .pdm_data(pdat),
        .start(start_m), .stop(stop_m), .cont(cont_m), .wr_valid(val_m), .wr_ready(rdy_m),
        .wr_addr(addr_m), .wr_data(data_m), .wr_ch(ch_m), .bsy(bsy_m), .done(done_m),
        .wrap(wrap_m), .ovf(ovf_m)
    );

    pdm_capture_multi #(.WORD_W(8), .CH(2), .DEPTH(4), .ADDR_W(2), .SYNC_STG(2)) u_stereo (
        .ahb_clk(ahb_clk), .rst(rst), .pdm_clk_in(pclk), .pdm_data(pdat),
        .start(start_s), .stop(stop_s), .cont(cont_s), .wr_valid(val_s), .wr_ready(rdy_s),
        .wr_addr(addr_s), .wr_data(data_s), .wr_ch(ch_s), .bsy(bsy_s), .done(done_s),
        .wrap(wrap_s), .ovf(ovf_s)
    );

    always #5 ahb_clk = ~ahb_clk;
    always @(posedge ahb_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // write scoreboards: every accepted write must match the head of its queue
    always @(negedge ahb_clk) begin
        if (wrap_m) begin
            wrap_cnt++;
            check("wrap_after_addr3", 32'(last_addr_m), 3);
        end
        if (done_m) begin
            done_cnt_m++;
            done_cyc_m = cyc;
            done_bsy_m = bsy_m;
        end
        if (val_m && rdy_m) begin
            em = qm.size() > 0 ? qm.pop_front() : wr_t'('x);
            check("mono_write", 32'({addr_m, data_m, ch_m}), 32'(em));
            last_addr_m = addr_m;
            acc_cyc_m   = cyc;
        end
        if (done_s) begin
            done_cnt_s++;
            done_cyc_s = cyc;
            done_bsy_s = bsy_s;
        end
        if (val_s && rdy_s) begin
            es = qs.size() > 0 ? qs.pop_front() : wr_t'('x);
            check("stereo_write", 32'({addr_s, data_s, ch_s}), 32'(es));
            acc_cyc_s = cyc;
        end
    end

    task automatic pbit(input logic b0, input logic b1);
        pdat = b0; repeat (2) @(negedge ahb_clk);
        pclk = 1'b1; repeat (2) @(negedge ahb_clk);
        pdat = b1; repeat (2) @(negedge ahb_clk);
        pclk = 1'b0; repeat (2) @(negedge ahb_clk);
    endtask

    task automatic pword(input logic [7:0] w0, input logic [7:0] w1, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) pbit(w0[i], w1[i]);
    endtask

    task automatic wait_done(input bit stereo, input int b);
        for (int i = 0; i < 40 && (stereo ? done_cnt_s : done_cnt_m) == b; i++) @(negedge ahb_clk);
        check(stereo ? "stereo_done_seen" : "mono_done_seen", stereo ? done_cnt_s : done_cnt_m, b + 1);
    endtask

    initial begin
        repeat (3) @(negedge ahb_clk);
        check("rst_valid", val_m, 0);
        check("rst_addr", addr_m, 0);
        check("rst_data", data_m, 0);
        check("rst_bsy", bsy_m, 0);
        check("rst_done_wrap_ovf", {done_m, wrap_m, ovf_m}, 0);
        check("rst_stereo_valid", val_s, 0);
        rst = 1'b1;
        @(negedge ahb_clk);

        // single-shot mono: four 0xA5 words then done
        base = done_cnt_m;
        cont_m = 1'b0; start_m = 1'b1; @(negedge ahb_clk); start_m = 1'b0;
        check("ss_arm_bsy", bsy_m, 1);
        for (int k = 0; k < 4; k++) qm.push_back('{2'(k), 8'hA5, 1'b0});
        repeat (4) pword(8'hA5, 8'h00, 8);
        wait_done(1'b0, base);
        check("ss_done_latency", done_cyc_m - acc_cyc_m, 1);
        check("ss_bsy_with_done", done_bsy_m, 0);
        check("ss_queue_empty", qm.size(), 0);

        // stereo: ch0 0x3C on rises, ch1 0xC3 on falls, interleaved
        base = done_cnt_s;
        cont_s = 1'b0; start_s = 1'b1; @(negedge ahb_clk); start_s = 1'b0;
        for (int k = 0; k < 4; k++) qs.push_back('{2'(k), k % 2 ? 8'hC3 : 8'h3C, 1'(k % 2)});
        repeat (2) pword(8'h3C, 8'hC3, 8);
        wait_done(1'b1, base);
        check("st_done_latency", done_cyc_s - acc_cyc_s, 1);
        check("st_bsy_with_done", done_bsy_s, 0);
        check("st_queue_empty", qs.size(), 0);

        // continuous: six words wrap the 4-deep buffer once
        base = done_cnt_m; wrap_cnt = 0;
        cont_m = 1'b1; start_m = 1'b1; @(negedge ahb_clk); start_m = 1'b0;
        for (int k = 0; k < 6; k++) qm.push_back('{2'(k % 4), pat[k], 1'b0});
        for (int k = 0; k < 6; k++) pword(pat[k], 8'h00, 8);
        repeat (4) @(negedge ahb_clk);
        check("cont_wrap_count", wrap_cnt, 1);
        check("cont_no_done", done_cnt_m, base);
        check("cont_queue_empty", qm.size(), 0);
        check("cont_next_addr", addr_m, 2);
        stop_m = 1'b1; @(negedge ahb_clk); stop_m = 1'b0;
        wait_done(1'b0, base);

        // backpressure: second word overflows, first retained
        base = done_cnt_m;
        rdy_m = 1'b0; cont_m = 1'b1; start_m = 1'b1; @(negedge ahb_clk); start_m = 1'b0;
        pword(8'h5A, 8'h00, 8);
        pword(8'h77, 8'h00, 8);
        repeat (4) @(negedge ahb_clk);
        check("bp_ovf", ovf_m, 1);
        check("bp_valid", val_m, 1);
        check("bp_data_kept", data_m, 8'h5A);
        check("bp_addr", addr_m, 0);
        qm.push_back('{2'd0, 8'h5A, 1'b0});
        rdy_m = 1'b1;
        repeat (3) @(negedge ahb_clk);
        check("bp_queue_empty", qm.size(), 0);
        check("bp_addr_after", addr_m, 1);
        stop_m = 1'b1; @(negedge ahb_clk); stop_m = 1'b0;
        wait_done(1'b0, base);
        check("bp_ovf_sticky", ovf_m, 1);
        base = done_cnt_m;
        cont_m = 1'b0; start_m = 1'b1; @(negedge ahb_clk); start_m = 1'b0;
        check("start_clears_ovf", ovf_m, 0);

        // stop after 3 bits of a second word while the first is held
        rdy_m = 1'b0;
        pword(8'hE7, 8'h00, 8);
        pword(8'h3F, 8'h00, 3);
        repeat (2) @(negedge ahb_clk);
        check("drain_held_valid", val_m, 1);
        stop_m = 1'b1; @(negedge ahb_clk); stop_m = 1'b0;
        qm.push_back('{2'd0, 8'hE7, 1'b0});
        rdy_m = 1'b1;
        wait_done(1'b0, base);
        check("drain_addr_plus1", addr_m, 1);
        check("drain_queue_empty", qm.size(), 0);

        // asynchronous reset with a word presented
        rdy_m = 1'b0; cont_m = 1'b1; start_m = 1'b1; @(negedge ahb_clk); start_m = 1'b0;
        pword(8'h96, 8'h00, 8);
        repeat (3) @(negedge ahb_clk);
        check("pre_rst_valid", val_m, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", val_m, 0);
        check("async_rst_bsy", bsy_m, 0);
        check("async_rst_outs", {addr_m, data_m, ch_m, done_m, wrap_m, ovf_m}, 0);
        @(negedge ahb_clk); rst = 1'b1; @(negedge ahb_clk);
        check("post_rst_idle", bsy_m, 0);
        base = done_cnt_m;
        rdy_m = 1'b1; start_m = 1'b1; @(negedge ahb_clk); start_m = 1'b0;
        check("post_rst_arm", bsy_m, 1);
        qm.push_back('{2'd0, 8'h69, 1'b0});
        pword(8'h69, 8'h00, 8);
        repeat (4) @(negedge ahb_clk);
        check("post_rst_queue_empty", qm.size(), 0);
        check("post_rst_addr", addr_m, 1);
        stop_m = 1'b1; @(negedge ahb_clk); stop_m = 1'b0;
        wait_done(1'b0, base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
